// File: rtl/inst_fetch_if.sv
// Fetch-unit bus bundle: ROM initiator port, redirect input, decode handshake.
// master = fetch unit, slave = ROM/execute/decode side. Optional FETCH_PERF_CNT_EN counters.
interface inst_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 64
);
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0] rom_inst;
  logic              br_valid;
  logic [ADDR_W-1:0] br_target;
  logic              id_ready;
  logic              if_valid;
  logic [INST_W-1:0] if_inst;
  logic [ADDR_W-1:0] if_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]       fetch_cnt;
  logic [31:0]       stall_cnt;
`endif

  modport master (
    output rom_ce, rom_addr,
    input  rom_inst,
    input  br_valid, br_target,
    input  id_ready,
    output if_valid, if_inst, if_pc
`ifdef FETCH_PERF_CNT_EN
    , output fetch_cnt, stall_cnt
`endif
  );

  modport slave (
    input  rom_ce, rom_addr,
    output rom_inst,
    output br_valid, br_target,
    output id_ready,
    input  if_valid, if_inst, if_pc
`ifdef FETCH_PERF_CNT_EN
    , input fetch_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: drives ROM, buffers words+PC in a 2-entry FIFO for decode.
// Ports: clk, rst (sync, active-high), bus (inst_fetch_if.master). Macro: FETCH_PERF_CNT_EN.
module inst_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 64,
  parameter int                PC_STEP  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  inst_fetch_if.master bus
);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [1:0]        r_cnt;
  logic [INST_W-1:0] r_inst0;
  logic [INST_W-1:0] r_inst1;
  logic [ADDR_W-1:0] r_pc0;
  logic [ADDR_W-1:0] r_pc1;

  logic w_run;
  logic w_valid;
  logic w_pop;
  logic w_br;
  logic w_fetch;
  logic w_full;

  // Everything is gated by rst so outputs read zero while reset is held.
  assign w_run   = (r_state == S_RUN) & ~rst;
  assign w_full  = (r_cnt == 2'd2);
  assign w_valid = (r_cnt != 2'd0) & ~rst;
  assign w_pop   = w_valid & bus.id_ready;
  assign w_br    = w_run & bus.br_valid;
  assign w_fetch = w_run & (~w_full | w_pop) & ~bus.br_valid;

  always_comb begin
    w_state_nxt  = r_state;
    bus.rom_ce   = 1'b0;
    bus.rom_addr = '0;
    bus.if_valid = 1'b0;
    bus.if_inst  = '0;
    bus.if_pc    = '0;
    case (r_state)
      S_IDLE:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_fetch) begin
      bus.rom_ce   = 1'b1;
      bus.rom_addr = r_pc;
    end
    if (w_valid) begin
      bus.if_valid = 1'b1;
      bus.if_inst  = r_inst0;
      bus.if_pc    = r_pc0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_cnt   <= 2'd0;
      r_inst0 <= '0;
      r_inst1 <= '0;
      r_pc0   <= '0;
      r_pc1   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_br) begin
        // Redirect flushes the FIFO; a same-cycle pop is dropped.
        r_cnt <= 2'd0;
        r_pc  <= {bus.br_target[ADDR_W-1:4], 4'b0};
      end else begin
        if (w_fetch) begin
          r_pc <= r_pc + ADDR_W'(PC_STEP);
        end
        case ({w_fetch, w_pop})
          2'b11: begin
            if (w_full) begin
              r_inst0 <= r_inst1;
              r_pc0   <= r_pc1;
              r_inst1 <= bus.rom_inst;
              r_pc1   <= r_pc;
            end else begin
              r_inst0 <= bus.rom_inst;
              r_pc0   <= r_pc;
            end
          end
          2'b10: begin
            if (r_cnt == 2'd0) begin
              r_inst0 <= bus.rom_inst;
              r_pc0   <= r_pc;
            end else begin
              r_inst1 <= bus.rom_inst;
              r_pc1   <= r_pc;
            end
            r_cnt <= r_cnt + 2'd1;
          end
          2'b01: begin
            r_inst0 <= r_inst1;
            r_pc0   <= r_pc1;
            r_cnt   <= r_cnt - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_fetch) r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (w_run & w_full & ~w_pop) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign bus.fetch_cnt = r_fetch_cnt;
  assign bus.stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: per-cycle vector table plus a transfer scoreboard.
// ROM model returns 0x1000 + slot index for every address.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst;

  inst_fetch_if #(.ADDR_W(32), .INST_W(64)) bus ();

  inst_fetch #(
    .ADDR_W(32), .INST_W(64), .PC_STEP(16), .RESET_PC(32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.rom_inst = 64'(bus.rom_addr >> 4) + 64'h1000;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        ce;
    logic [31:0] addr;
    logic        v;
    logic [31:0] pc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;

  function automatic vec_t mk(logic r, logic rdy, logic br,
                              logic [31:0] tgt, logic ce,
                              logic [31:0] addr, logic v,
                              logic [31:0] pc);
    vec_t t;
    t.rst = r; t.rdy = rdy; t.br = br; t.tgt = tgt;
    t.ce = ce; t.addr = addr; t.v = v; t.pc = pc;
    return t;
  endfunction

  function automatic logic [63:0] rom_word(logic [31:0] pc);
    return 64'(pc >> 4) + 64'h1000;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(vec_t t);
    logic [31:0] e;
    @(negedge clk);
    rst           = t.rst;
    bus.id_ready  = t.rdy;
    bus.br_valid  = t.br;
    bus.br_target = t.tgt;
    #1;
    chk("rom_ce",   64'(bus.rom_ce),   64'(t.ce));
    chk("rom_addr", 64'(bus.rom_addr), 64'(t.addr));
    chk("if_valid", 64'(bus.if_valid), 64'(t.v));
    chk("if_pc",    64'(bus.if_pc),    64'(t.pc));
    chk("if_inst",  bus.if_inst, t.v ? rom_word(t.pc) : 64'h0);
    if (!t.rst && !t.br && t.rdy && bus.if_valid) begin
      if (sb.size() == 0) begin
        chk("sb_extra", 64'(bus.if_pc), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sb_pc",   64'(bus.if_pc), 64'(e));
        chk("sb_inst", bus.if_inst,    rom_word(e));
      end
    end
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst           = 1'b1;
    bus.id_ready  = 1'b0;
    bus.br_valid  = 1'b0;
    bus.br_target = '0;

    //            rst rdy br tgt            ce addr           v pc
    tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h10,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h20,        1, 32'h10));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h30,        1, 32'h20));
    tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h10,        1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h20,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h30,        1, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h20));
    tbl.push_back(mk(0, 0, 1, 32'h125,       0, 32'h0,         1, 32'h20));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h120,       0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h130,       1, 32'h120));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h140,       1, 32'h130));
    tbl.push_back(mk(0, 1, 1, 32'hFFFF_FFF0, 0, 32'h0,         1, 32'h130));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'hFFFF_FFF0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         1, 32'hFFFF_FFF0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h10,        1, 32'h0));
    tbl.push_back(mk(0, 0, 0, 32'h0,         1, 32'h20,        1, 32'h10));
    tbl.push_back(mk(0, 0, 0, 32'h0,         0, 32'h0,         1, 32'h10));
    tbl.push_back(mk(1, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h0,         0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h10,        1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 32'h0,         1, 32'h20,        1, 32'h10));

    // Expected transfers to decode, in delivery order.
    sb.push_back(32'h0);
    sb.push_back(32'h10);
    sb.push_back(32'h20);
    sb.push_back(32'h0);
    sb.push_back(32'h10);
    sb.push_back(32'h120);
    sb.push_back(32'hFFFF_FFF0);
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    sb.push_back(32'h10);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i]);
`ifdef FETCH_PERF_CNT_EN
      if (i == 28) begin
        chk("fetch_cnt_rst", 64'(bus.fetch_cnt), 64'h0);
        chk("stall_cnt_rst", 64'(bus.stall_cnt), 64'h0);
      end
`endif
    end

    // Back-to-back redirects: the second target wins.
    sb.push_back(32'h7A0);
    step(mk(0, 0, 1, 32'h500, 0, 32'h0,   1, 32'h20));
    step(mk(0, 0, 1, 32'h7A8, 0, 32'h0,   0, 32'h0));
    step(mk(0, 1, 0, 32'h0,   1, 32'h7A0, 0, 32'h0));
    step(mk(0, 1, 0, 32'h0,   1, 32'h7B0, 1, 32'h7A0));

    chk("sb_left", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end and initiator side of the instruction ROM interface.
- Generates `rom_ce` and `rom_addr` towards the combinational instruction ROM and captures the returned 64-bit word together with its PC.
- Buffers captured words in a 2-entry FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch redirects from execute, which flush the FIFO.

Parameters:
- ADDR_W, 32: width of the instruction address bus.
- INST_W, 64: width of the instruction word.
- PC_STEP, 16: byte stride between consecutive instruction slots. `rom_addr[3:0]` is always zero.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rom_ce  out  1  ROM chip enable. 1 = `ChipEnable`, 0 = `ChipDisable`.
- rom_addr  out  ADDR_W  ROM fetch address.
- rom_inst  in  INST_W  ROM read data; combinational, valid in the same cycle as `rom_addr` while `rom_ce`=1.
- br_valid  in  1  redirect request, single-cycle pulse.
- br_target  in  ADDR_W  redirect address; bits [3:0] are ignored and treated as 0.
- id_ready  in  1  decode accepts the head entry this cycle.
- if_valid  out  1  head entry valid.
- if_inst  out  INST_W  head instruction.
- if_pc  out  ADDR_W  head PC.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high on `rst`. All state updates on the rising edge of `clk`.
- Values while `rst`=1:
  - `pc` = RESET_PC.
  - FIFO count = 0.
  - State = IDLE.
  - Outputs: `rom_ce`=0, `rom_addr`=0, `if_valid`=0, `if_inst`=0, `if_pc`=0.
- Reset asserted mid-operation:
  - Discards all buffered entries in that cycle.
  - Any `br_valid` in the same cycle is ignored.
- State IDLE:
  - Entered only via reset.
  - `rom_ce`=0.
  - Moves to RUN on the first clock with `rst`=0.
- State RUN:
  - `pop` = `if_valid` & `id_ready`.
  - `fetch` = (count<2 | `pop`) & ~`br_valid`.
  - `rom_ce` = `fetch`.
  - `rom_addr` = `pc` when `rom_ce`=1, otherwise 0.
- On `fetch`:
  - `{rom_inst, pc}` is pushed into the FIFO at the clock edge.
  - `pc` <= `pc` + PC_STEP, modulo 2^ADDR_W (0xFFFFFFF0 wraps to 0x00000000).
- Latency:
  - An address presented in cycle N appears on `if_inst`/`if_pc` with `if_valid`=1 in cycle N+1 at the earliest.
  - Throughput is 1 instruction per cycle while decode keeps `id_ready`=1.
- FIFO:
  - 2 entries, in-order.
  - Push and pop in the same cycle are legal at any count, including count=2.
  - At count=2 with no pop: `rom_ce`=0 and `pc` holds.
  - Count never exceeds 2 and never underflows.
  - `if_inst`/`if_pc` are driven from the head entry.
  - Outputs are stable while `if_valid`=1 and `id_ready`=0.
- Redirect (`br_valid`=1 in RUN) has priority over push and pop:
  - `rom_ce`=0 that cycle.
  - FIFO is cleared.
  - `pc` <= {`br_target`[ADDR_W-1:4], 4'b0}.
  - Any pop in that cycle is not counted as a transfer.
  - `if_valid`=0 in the following cycle.
  - The target is fetched in the following cycle and is valid one cycle later.
  - Back-to-back redirects: the last one wins.
- If `if_valid`=0, `if_inst` and `if_pc` are 0.

Optional Feature:
- Macro `FETCH_PERF_CNT_EN`.
- When defined:
  - Adds output `fetch_cnt` (32 bits), incremented on every push.
  - Adds output `stall_cnt` (32 bits), incremented on every RUN cycle with count=2 and no pop.
  - Both counters reset to 0 under `rst` and wrap at 2^32.
- When not defined: neither port nor counter exists, and behaviour is otherwise identical.

Test Plan:
- Reset release, `id_ready`=1 constantly, ROM word at slot k = 0x1000+k:
  - Cycle 1 after reset: `rom_ce`=1, `rom_addr`=0x0.
  - Next cycle: `if_valid`=1, `if_inst`=0x1000, `if_pc`=0x0.
  - Then one instruction per cycle at PCs 0x10, 0x20, 0x30.
- Backpressure, `id_ready`=0 for 5 cycles:
  - FIFO fills to 2 entries (PCs 0x0, 0x10).
  - `rom_ce`=0 and `rom_addr` holds at 0.
  - On release: PCs 0x0, 0x10, 0x20 delivered in order, no loss or duplication.
- Redirect `br_valid`=1, `br_target`=0x0000_0125 while FIFO holds 2 entries:
  - Next cycle: `if_valid`=0.
  - Following cycle: `if_pc`=0x120.
- Redirect in the same cycle as a pop with count=2: redirect wins, FIFO empty, and no entry after the flushed ones is delivered before the target PC.
- PC wrap, `br_target`=0xFFFF_FFF0: delivered PCs are 0xFFFF_FFF0 then 0x0000_0000.
- Reset mid-stream with 2 buffered entries: `if_valid`=0 while `rst`=1; after release the first delivered `if_pc` is RESET_PC. With `FETCH_PERF_CNT_EN` defined, `fetch_cnt`=0 and `stall_cnt`=0.
